// File: rtl/soc_err_slv_pkg.sv
// soc_err_slv_pkg: shared response code, default read data and FSM state types for the error slave.
package soc_err_slv_pkg;
    localparam logic [1:0]  RespDecErr      = 2'b11;
    localparam logic [63:0] RespDataDefault = 64'hBADC_AB1E_BADC_AB1E;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/soc_err_slv_if.sv
// soc_err_slv_if: AXI-lite-ish crossbar port of the error slave plus first-fault capture signals.
interface soc_err_slv_if #(
    parameter int IdWidth   = 5,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic                 aw_valid_i, aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic [AddrWidth-1:0] aw_addr_i;
    logic                 w_valid_i, w_ready_o, w_last_i;
    logic                 b_valid_o, b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [1:0]           b_resp_o;
    logic                 ar_valid_i, ar_ready_o;
    logic [IdWidth-1:0]   ar_id_i;
    logic [AddrWidth-1:0] ar_addr_i;
    logic [7:0]           ar_len_i;
    logic                 r_valid_o, r_ready_i, r_last_o;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic [1:0]           r_resp_o;
    logic                 err_valid_o, err_is_write_o, err_clr_i;
    logic [AddrWidth-1:0] err_addr_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
               ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i, err_clr_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o, ar_ready_o,
               r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
               err_valid_o, err_addr_o, err_is_write_o
    );
    modport master (
        output aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
               ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i, err_clr_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o, ar_ready_o,
               r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
               err_valid_o, err_addr_o, err_is_write_o
    );
endinterface

// File: rtl/soc_err_slv_rd.sv
// soc_err_slv_rd: read channel of the error slave; answers every AR burst with len+1 DECERR beats.
module soc_err_slv_rd
    import soc_err_slv_pkg::*;
#(
    parameter int          IdWidth   = 5,
    parameter int          DataWidth = 64,
    parameter logic [63:0] RespData  = RespDataDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ar_valid,
    input  logic [IdWidth-1:0]   ar_id,
    input  logic [7:0]           ar_len,
    output logic                 ar_ready,
    input  logic                 r_ready,
    output logic                 r_valid,
    output logic [IdWidth-1:0]   r_id,
    output logic [DataWidth-1:0] r_data,
    output logic [1:0]           r_resp,
    output logic                 r_last
);
    r_state_e             r_q, r_d;
    logic [7:0]           cnt_q, len_q;
    logic [IdWidth-1:0]   id_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q   <= R_IDLE;
            cnt_q <= '0;
            len_q <= '0;
            id_q  <= '0;
        end else begin
            r_q <= r_d;
            if (ar_valid && ar_ready) begin
                cnt_q <= '0;
                len_q <= ar_len;
                id_q  <= ar_id;
            end else if (r_valid && r_ready && !r_last) begin
                // the final beat does not advance the counter, so a 256-beat burst never wraps it
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        r_d = r_q;
        r_d = (r_q == R_IDLE) ? (ar_valid ? R_DATA : R_IDLE)
                              : ((r_ready && r_last) ? R_IDLE : R_DATA);
    end

    assign ar_ready = r_q == R_IDLE;
    assign r_valid  = r_q == R_DATA;
    assign r_last   = r_valid && (cnt_q == len_q);
    assign r_id     = id_q;
    assign r_data   = RespData[DataWidth-1:0];
    assign r_resp   = RespDecErr;
endmodule

// File: rtl/soc_err_slv.sv
// soc_err_slv: crossbar error slave returning DECERR on every B and R beat for unmapped addresses.
// Define SOC_ERR_SLV_CAPTURE_EN to enable first-fault address capture on the err_* signals.
module soc_err_slv
    import soc_err_slv_pkg::*;
#(
    parameter int          IdWidth   = 5,
    parameter int          AddrWidth = 64,
    parameter int          DataWidth = 64,
    parameter logic [63:0] RespData  = RespDataDefault
) (
    input logic          clk_i,
    input logic          rst_i,
    soc_err_slv_if.slave bus
);
    w_state_e           w_q, w_d;
    logic [IdWidth-1:0] wid_q;
    logic               aw_hs, ar_hs;

    assign aw_hs = bus.aw_valid_i && bus.aw_ready_o;
    assign ar_hs = bus.ar_valid_i && bus.ar_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_q   <= W_IDLE;
            wid_q <= '0;
        end else begin
            w_q <= w_d;
            if (aw_hs) wid_q <= bus.aw_id_i;
        end
    end

    always_comb begin
        w_d = w_q;
        w_d = (w_q == W_IDLE && bus.aw_valid_i)                 ? W_DATA :
              (w_q == W_DATA && bus.w_valid_i && bus.w_last_i)  ? W_RESP :
              (w_q == W_RESP && bus.b_ready_i)                  ? W_IDLE : w_q;
    end

    assign bus.aw_ready_o = w_q == W_IDLE;
    assign bus.w_ready_o  = w_q == W_DATA;
    assign bus.b_valid_o  = w_q == W_RESP;
    assign bus.b_id_o     = wid_q;
    assign bus.b_resp_o   = RespDecErr;

    soc_err_slv_rd #(
        .IdWidth  (IdWidth),
        .DataWidth(DataWidth),
        .RespData (RespData)
    ) u_rd (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ar_valid(bus.ar_valid_i),
        .ar_id   (bus.ar_id_i),
        .ar_len  (bus.ar_len_i),
        .ar_ready(bus.ar_ready_o),
        .r_ready (bus.r_ready_i),
        .r_valid (bus.r_valid_o),
        .r_id    (bus.r_id_o),
        .r_data  (bus.r_data_o),
        .r_resp  (bus.r_resp_o),
        .r_last  (bus.r_last_o)
    );

`ifdef SOC_ERR_SLV_CAPTURE_EN
    logic                 err_v_q, err_w_q;
    logic [AddrWidth-1:0] err_a_q;

    // a clear in the same cycle as a new fault re-arms and captures that fault; AW wins over AR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_v_q <= 1'b0;
            err_w_q <= 1'b0;
            err_a_q <= '0;
        end else if ((!err_v_q || bus.err_clr_i) && (aw_hs || ar_hs)) begin
            err_v_q <= 1'b1;
            err_w_q <= aw_hs;
            err_a_q <= aw_hs ? bus.aw_addr_i : bus.ar_addr_i;
        end else if (bus.err_clr_i) begin
            err_v_q <= 1'b0;
        end
    end

    assign bus.err_valid_o    = err_v_q;
    assign bus.err_is_write_o = err_w_q;
    assign bus.err_addr_o     = err_a_q;
`else
    assign bus.err_valid_o    = 1'b0;
    assign bus.err_is_write_o = 1'b0;
    assign bus.err_addr_o     = '0;
`endif
endmodule

// File: tb/tb_soc_err_slv.sv
// tb_soc_err_slv: directed and randomized checks of soc_err_slv against a beat-counting transaction model.
module tb_soc_err_slv;
    localparam logic [63:0] RD = 64'hBADC_AB1E_BADC_AB1E;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    soc_err_slv_if #(.IdWidth(5), .AddrWidth(64), .DataWidth(64)) bus ();

    soc_err_slv dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aw_valid_i = 0; bus.aw_id_i = '0; bus.aw_addr_i = '0;
        bus.w_valid_i  = 0; bus.w_last_i = 0; bus.b_ready_i = 0;
        bus.ar_valid_i = 0; bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0;
        bus.r_ready_i  = 0; bus.err_clr_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    // transaction model state for the random phase
    logic       w_busy, b_pend, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int         w_left, r_left, beats, lasts, last_at;
    logic [4:0] b_id_exp, r_id_exp;
    logic       e_v, e_w;
    logic [63:0] e_a;

    initial begin
        do_reset();
        // outputs straight after reset
        chk("rst_aw_ready", bus.aw_ready_o, 1);
        chk("rst_ar_ready", bus.ar_ready_o, 1);
        chk("rst_w_ready", bus.w_ready_o, 0);
        chk("rst_b_valid", bus.b_valid_o, 0);
        chk("rst_r_valid", bus.r_valid_o, 0);
        chk("rst_r_last", bus.r_last_o, 0);
        chk("rst_b_id", bus.b_id_o, 0);
        chk("rst_r_id", bus.r_id_o, 0);
        chk("rst_b_resp", bus.b_resp_o, 2'b11);
        chk("rst_r_resp", bus.r_resp_o, 2'b11);
        chk("rst_r_data", bus.r_data_o, RD);
        chk("rst_err_valid", bus.err_valid_o, 0);
        chk("rst_err_addr", bus.err_addr_o, 0);
        chk("rst_err_wr", bus.err_is_write_o, 0);

        // minimum-latency write: AW at N, W at N+1, B at N+2, AW ready again at N+3
        bus.aw_valid_i = 1; bus.aw_id_i = 5'h3; bus.aw_addr_i = 64'h1234;
        tick();
        bus.aw_valid_i = 0; bus.w_valid_i = 1; bus.w_last_i = 1;
        chk("wr_aw_ready_busy", bus.aw_ready_o, 0);
        chk("wr_w_ready", bus.w_ready_o, 1);
        chk("wr_b_early", bus.b_valid_o, 0);
        tick();
        bus.w_valid_i = 0; bus.w_last_i = 0; bus.b_ready_i = 1;
        chk("wr_b_valid", bus.b_valid_o, 1);
        chk("wr_b_id", bus.b_id_o, 5'h3);
        chk("wr_b_resp", bus.b_resp_o, 2'b11);
        tick();
        bus.b_ready_i = 0;
        chk("wr_b_done", bus.b_valid_o, 0);
        chk("wr_aw_ready_back", bus.aw_ready_o, 1);

        // len=3 burst with r_ready toggling; outputs must hold while stalled
        bus.ar_valid_i = 1; bus.ar_id_i = 5'h11; bus.ar_len_i = 8'd3;
        tick();
        bus.ar_valid_i = 0;
        beats = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            bus.r_ready_i = (c % 2 == 0);
            chk("r4_valid", bus.r_valid_o, 1);
            chk("r4_last", bus.r_last_o, beats == 3);
            chk("r4_data", bus.r_data_o, RD);
            chk("r4_id", bus.r_id_o, 5'h11);
            chk("r4_resp", bus.r_resp_o, 2'b11);
            if (bus.r_ready_i) beats++;
            tick();
        end
        bus.r_ready_i = 0;
        chk("r4_beats", 64'(beats), 4);
        chk("r4_valid_end", bus.r_valid_o, 0);
        chk("r4_ar_ready", bus.ar_ready_o, 1);

        // len=255 burst: 256 beats, r_last only on the last one
        bus.ar_valid_i = 1; bus.ar_id_i = 5'h7; bus.ar_len_i = 8'd255;
        tick();
        bus.ar_valid_i = 0; bus.r_ready_i = 1;
        beats = 0; lasts = 0; last_at = 0;
        for (int c = 0; c < 300; c++) begin
            if (!bus.r_valid_o) break;
            beats++;
            if (bus.r_last_o) begin lasts++; last_at = beats; end
            tick();
        end
        bus.r_ready_i = 0;
        chk("r256_beats", 64'(beats), 256);
        chk("r256_last_at", 64'(last_at), 256);
        chk("r256_last_count", 64'(lasts), 1);
        chk("r256_ar_ready", bus.ar_ready_o, 1);

        // simultaneous AW + AR; first-fault capture when enabled
        do_reset();
        bus.aw_valid_i = 1; bus.aw_id_i = 5'h1; bus.aw_addr_i = 64'h7000_0000;
        bus.ar_valid_i = 1; bus.ar_id_i = 5'h2; bus.ar_addr_i = 64'h7000_1000; bus.ar_len_i = 0;
        chk("sim_aw_ready", bus.aw_ready_o, 1);
        chk("sim_ar_ready", bus.ar_ready_o, 1);
        tick();
        bus.aw_valid_i = 0; bus.ar_valid_i = 0;
        chk("sim_aw_taken", bus.aw_ready_o, 0);
        chk("sim_ar_taken", bus.ar_ready_o, 0);
        chk("sim_r_valid", bus.r_valid_o, 1);
        chk("sim_r_last", bus.r_last_o, 1);
        chk("sim_r_id", bus.r_id_o, 5'h2);
`ifdef SOC_ERR_SLV_CAPTURE_EN
        chk("cap_valid", bus.err_valid_o, 1);
        chk("cap_addr", bus.err_addr_o, 64'h7000_0000);
        chk("cap_wr", bus.err_is_write_o, 1);
`else
        chk("nocap_valid", bus.err_valid_o, 0);
        chk("nocap_addr", bus.err_addr_o, 0);
`endif
        bus.w_valid_i = 1; bus.w_last_i = 1; bus.r_ready_i = 1; bus.b_ready_i = 1;
        tick();
        bus.w_valid_i = 0; bus.w_last_i = 0;
        chk("sim_b_valid", bus.b_valid_o, 1);
        chk("sim_b_id", bus.b_id_o, 5'h1);
        chk("sim_r_done", bus.r_valid_o, 0);
        tick();
        chk("sim_aw_back", bus.aw_ready_o, 1);
        bus.ar_valid_i = 1; bus.ar_addr_i = 64'h8000; bus.ar_len_i = 0;
        tick();
        bus.ar_valid_i = 0;
`ifdef SOC_ERR_SLV_CAPTURE_EN
        chk("cap_hold_addr", bus.err_addr_o, 64'h7000_0000);
        chk("cap_hold_wr", bus.err_is_write_o, 1);
`endif
        tick();
        bus.err_clr_i = 1;
        tick();
        bus.err_clr_i = 0;
        chk("clr_valid", bus.err_valid_o, 0);
        bus.ar_valid_i = 1; bus.ar_addr_i = 64'h9000;
        tick();
        bus.ar_valid_i = 0;
`ifdef SOC_ERR_SLV_CAPTURE_EN
        chk("cap2_valid", bus.err_valid_o, 1);
        chk("cap2_addr", bus.err_addr_o, 64'h9000);
        chk("cap2_wr", bus.err_is_write_o, 0);
`endif
        tick();
        bus.ar_valid_i = 1; bus.ar_addr_i = 64'hA000; bus.err_clr_i = 1;
        tick();
        bus.ar_valid_i = 0; bus.err_clr_i = 0;
`ifdef SOC_ERR_SLV_CAPTURE_EN
        chk("clrwin_valid", bus.err_valid_o, 1);
        chk("clrwin_addr", bus.err_addr_o, 64'hA000);
`else
        chk("nocap_valid2", bus.err_valid_o, 0);
`endif
        tick();

        // reset during beat 2 of a len=7 burst abandons it
        do_reset();
        bus.ar_valid_i = 1; bus.ar_id_i = 5'h4; bus.ar_len_i = 8'd7;
        tick();
        bus.ar_valid_i = 0; bus.r_ready_i = 1;
        chk("rb_beat1", bus.r_valid_o, 1);
        tick();
        chk("rb_beat2", bus.r_valid_o, 1);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("rb_valid", bus.r_valid_o, 0);
        chk("rb_ar_ready", bus.ar_ready_o, 1);
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.r_valid_o) beats++;
            tick();
        end
        chk("rb_no_beats", 64'(beats), 0);

        // random concurrent traffic against the transaction model
        do_reset();
        w_busy = 0; b_pend = 0; w_left = 0; r_left = 0; b_id_exp = '0; r_id_exp = '0;
        e_v = 0; e_w = 0; e_a = '0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_aw_ready", bus.aw_ready_o, !w_busy);
            chk("rnd_w_ready", bus.w_ready_o, w_busy && !b_pend);
            chk("rnd_b_valid", bus.b_valid_o, b_pend);
            if (b_pend) chk("rnd_b_id", bus.b_id_o, b_id_exp);
            chk("rnd_ar_ready", bus.ar_ready_o, r_left == 0);
            chk("rnd_r_valid", bus.r_valid_o, r_left != 0);
            if (r_left != 0) begin
                chk("rnd_r_last", bus.r_last_o, r_left == 1);
                chk("rnd_r_id", bus.r_id_o, r_id_exp);
                chk("rnd_r_data", bus.r_data_o, RD);
                chk("rnd_r_resp", bus.r_resp_o, 2'b11);
            end
`ifdef SOC_ERR_SLV_CAPTURE_EN
            chk("rnd_err_valid", bus.err_valid_o, e_v);
            if (e_v) begin
                chk("rnd_err_addr", bus.err_addr_o, e_a);
                chk("rnd_err_wr", bus.err_is_write_o, e_w);
            end
`else
            chk("rnd_err_off", {bus.err_valid_o, bus.err_is_write_o, bus.err_addr_o[61:0]}, 0);
`endif
            bus.aw_valid_i = ($urandom_range(0, 3) == 0);
            bus.aw_id_i    = 5'($urandom);
            bus.aw_addr_i  = {$urandom, $urandom};
            bus.w_valid_i  = 1'($urandom_range(0, 1));
            bus.w_last_i   = w_busy ? (w_left == 1) : 1'($urandom_range(0, 1));
            bus.b_ready_i  = ($urandom_range(0, 2) != 0);
            bus.ar_valid_i = ($urandom_range(0, 3) == 0);
            bus.ar_id_i    = 5'($urandom);
            bus.ar_addr_i  = {$urandom, $urandom};
            bus.ar_len_i   = 8'($urandom_range(0, 7));
            bus.r_ready_i  = 1'($urandom_range(0, 1));
            bus.err_clr_i  = ($urandom_range(0, 15) == 0);
            aw_hs = bus.aw_valid_i && !w_busy;
            w_hs  = bus.w_valid_i && w_busy && !b_pend;
            b_hs  = b_pend && bus.b_ready_i;
            ar_hs = bus.ar_valid_i && r_left == 0;
            r_hs  = r_left != 0 && bus.r_ready_i;
            if ((!e_v || bus.err_clr_i) && (aw_hs || ar_hs)) begin
                e_v = 1; e_w = aw_hs; e_a = aw_hs ? bus.aw_addr_i : bus.ar_addr_i;
            end else if (bus.err_clr_i) e_v = 0;
            if (aw_hs) begin w_busy = 1; w_left = $urandom_range(1, 4); b_id_exp = bus.aw_id_i; end
            if (w_hs) begin w_left--; if (w_left == 0) b_pend = 1; end
            if (b_hs) begin w_busy = 0; b_pend = 0; end
            if (ar_hs) begin r_left = int'(bus.ar_len_i) + 1; r_id_exp = bus.ar_id_i; end
            if (r_hs) r_left--;
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
